uart_rx_byte: RTL and testbench

UART receiver for the board's serial input. Synchronises uart_rx0, detects and validates the start bit, samples 8N1 frames at mid-bit and presents each received byte on a valid/ready output. Sits directly downstream of the uart_rx0 pad and upstream of byte consumers such as the hexplay/LED display logic or a TX echo path.

---
 rtl/uart_pkg.sv | 33 +++
 rtl/sync_2ff.sv | 36 +++
 rtl/uart_rx_byte.sv | 185 ++++++++++++++++++
 tb/tb_uart_rx_byte.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared UART definitions: receiver FSM state encoding, frame geometry,
// default clock/baud constants and a constant-evaluable clog2 helper.
// Imported by uart_rx_byte and intended for reuse by a future uart_tx_byte.
// -----------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_e;

  localparam int DATA_BITS    = 8;
  localparam int DEF_CLK_FREQ = 100000000;
  localparam int DEF_BAUD     = 115200;

  // Bits needed to hold values 0..value-1, never less than 1.
  function automatic int clog2(input int value);
    int width;
    int rem;
    width = 32'sd0;
    rem   = value - 32'sd1;
    while (rem > 32'sd0) begin
      width = width + 32'sd1;
      rem   = rem >>> 1;
    end
    return (width < 32'sd1) ? 32'sd1 : width;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Two-flop synchroniser for asynchronous level inputs. Both stages reset to
// all-ones so an idle-high serial line does not look like a start bit while
// the chain refills after reset.
//   clk_i  : destination clock
//   rst_i  : synchronous active-high reset
//   d_i    : asynchronous input bus
//   q_o    : synchronised output, two clocks of latency
// -----------------------------------------------------------------------------
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // Two-stage capture chain.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_byte.sv
// -----------------------------------------------------------------------------
// uart_rx_byte
// 8N1 UART receiver. The serial line is synchronised, the start bit is
// validated at its centre, data bits are sampled at mid-bit LSB first and the
// completed byte is offered on a valid/ready interface.
//   clk        : system clock
//   rst        : synchronous active-high reset
//   uart_rx0   : asynchronous serial line, idle high
//   rx_data    : received byte
//   rx_valid   : rx_data holds an unconsumed byte
//   rx_ready   : consumer accepts when rx_valid && rx_ready
//   frame_err  : one-cycle pulse, stop bit sampled low
//   overrun    : one-cycle pulse, unconsumed byte overwritten
//   busy       : receiver is not idle
// -----------------------------------------------------------------------------
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = DEF_CLK_FREQ,
  parameter int BAUD     = DEF_BAUD
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 uart_rx0,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int CW           = clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0]    IDX_LAST = 3'(DATA_BITS - 1);

  if (CLKS_PER_BIT < 4) begin : g_bad_cpb
    $error("uart_rx_byte: CLK_FREQ/BAUD must be at least 4");
  end

  logic                 rxd_s;
  logic                 accept_s;
  logic                 complete_s;

  rx_state_e            state_q,     state_d;
  logic [CW-1:0]        baud_q,      baud_d;
  logic [2:0]           bit_idx_q,   bit_idx_d;
  logic [DATA_BITS-1:0] shift_q,     shift_d;
  // Cleared by a framing error so a held-low (break) line cannot retrigger.
  logic                 armed_q,     armed_d;
  logic [DATA_BITS-1:0] rx_data_q,   rx_data_d;
  logic                 rx_valid_q,  rx_valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q,   overrun_d;
  logic                 busy_q,      busy_d;

  sync_2ff #(.WIDTH(1)) u_sync (
    .clk_i (clk),
    .rst_i (rst),
    .d_i   (uart_rx0),
    .q_o   (rxd_s)
  );

  assign accept_s = rx_valid_q & rx_ready;

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      baud_q      <= '0;
      bit_idx_q   <= 3'd0;
      shift_q     <= '0;
      armed_q     <= 1'b1;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      baud_q      <= baud_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      armed_q     <= armed_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state, bit sampling and output-register update.
  always_comb begin
    state_d     = state_q;
    baud_d      = baud_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    armed_d     = armed_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    complete_s  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        baud_d = '0;
        if (rxd_s) begin
          armed_d = 1'b1;
        end else if (armed_q) begin
          state_d = ST_START;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (baud_q == CNT_HALF) begin
          baud_d = '0;
          if (!rxd_s) begin
            state_d   = ST_DATA;
            bit_idx_d = 3'd0;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
      ST_DATA: begin
        if (baud_q == CNT_LAST) begin
          baud_d             = '0;
          shift_d[bit_idx_q] = rxd_s;
          if (bit_idx_q == IDX_LAST) begin
            state_d = ST_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
      ST_STOP: begin
        if (baud_q == CNT_LAST) begin
          baud_d  = '0;
          state_d = ST_IDLE;
          if (rxd_s) begin
            complete_s = 1'b1;
          end else begin
            frame_err_d = 1'b1;
            armed_d     = 1'b0;
          end
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        baud_d  = '0;
      end
    endcase

    // A completion in the same cycle as an accept replaces the byte cleanly.
    if (complete_s) begin
      rx_data_d  = shift_q;
      rx_valid_d = 1'b1;
      overrun_d  = rx_valid_q & ~rx_ready;
    end else if (accept_s) begin
      rx_valid_d = 1'b0;
    end else begin
      rx_valid_d = rx_valid_q;
    end

    busy_d = (state_d != ST_IDLE);
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_uart_rx_byte.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_uart_rx_byte
// Directed bench for uart_rx_byte at 10 clocks per bit. Expected bytes are
// queued when a frame is sent and popped when the consumer accepts one.
// -----------------------------------------------------------------------------
module tb_uart_rx_byte;

  localparam int CLK_FREQ = 1000000;
  localparam int BAUD     = 100000;
  localparam int BIT_NS   = 100;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       uart_rx0 = 1'b1;
  logic       rx_ready = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] exp_q[$];
  int         acc_cnt = 0;
  int         ferr_cyc = 0;
  int         ovr_cnt = 0;
  bit         saw_busy = 1'b0;

  uart_rx_byte #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
    .clk       (clk),
    .rst       (rst),
    .uart_rx0  (uart_rx0),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives one 8N1 frame; bit_ns sets the (possibly skewed) bit period.
  task automatic send_byte(input logic [7:0] b, input logic stop_v, input int bit_ns);
    uart_rx0 = 1'b0;
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      uart_rx0 = b[i];
      #(bit_ns);
    end
    uart_rx0 = stop_v;
    #(bit_ns);
  endtask

  // Output monitor and scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    logic [7:0] e;
    if (!rst) begin
      if (busy) saw_busy = 1'b1;
      if (frame_err) ferr_cyc++;
      if (overrun) begin
        ovr_cnt++;
        if (exp_q.size() > 0) e = exp_q.pop_front();
      end
      if (rx_valid && rx_ready) begin
        acc_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_byte", {24'd0, rx_data}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("rx_data", {24'd0, rx_data}, {24'd0, e});
        end
      end
    end
  end

  initial begin
    int a0;
    int f0;

    // Reset state.
    rst = 1'b1; uart_rx0 = 1'b1; rx_ready = 1'b1;
    wait_clks(3);
    check("rst_rx_data",   {24'd0, rx_data}, 32'h0);
    check("rst_rx_valid",  {31'd0, rx_valid}, 32'h0);
    check("rst_busy",      {31'd0, busy}, 32'h0);
    check("rst_frame_err", {31'd0, frame_err}, 32'h0);
    check("rst_overrun",   {31'd0, overrun}, 32'h0);
    rst = 1'b0;
    wait_clks(5);

    // Plain byte.
    exp_q.push_back(8'hA5);
    send_byte(8'hA5, 1'b1, BIT_NS);
    wait_clks(20);
    check("a5_accepts", acc_cnt, 32'd1);
    check("a5_ferr",    ferr_cyc, 32'd0);
    check("a5_ovr",     ovr_cnt, 32'd0);
    check("a5_busy",    {31'd0, busy}, 32'h0);
    check("a5_queue",   exp_q.size(), 32'd0);

    // Short low glitch rejected at start-bit centre.
    saw_busy = 1'b0; a0 = acc_cnt;
    uart_rx0 = 1'b0;
    wait_clks(3);
    uart_rx0 = 1'b1;
    wait_clks(10);
    check("glitch_saw_busy", {31'd0, saw_busy}, 32'h1);
    check("glitch_busy",     {31'd0, busy}, 32'h0);
    check("glitch_accepts",  acc_cnt, a0);
    check("glitch_valid",    {31'd0, rx_valid}, 32'h0);

    // Stop bit low, line then held low (break).
    f0 = ferr_cyc;
    send_byte(8'h3C, 1'b0, BIT_NS);
    wait_clks(30);
    check("ferr_pulse_cycles", ferr_cyc - f0, 32'd1);
    check("ferr_valid",        {31'd0, rx_valid}, 32'h0);
    check("ferr_busy",         {31'd0, busy}, 32'h0);
    check("ferr_accepts",      acc_cnt, a0);
    saw_busy = 1'b0;
    wait_clks(20);
    check("break_no_restart", {31'd0, saw_busy}, 32'h0);
    uart_rx0 = 1'b1;
    wait_clks(10);

    // Overrun with consumer stalled.
    rx_ready = 1'b0;
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    send_byte(8'h11, 1'b1, BIT_NS);
    send_byte(8'h22, 1'b1, BIT_NS);
    wait_clks(20);
    check("ovr_count", ovr_cnt, 32'd1);
    check("ovr_data",  {24'd0, rx_data}, 32'h22);
    check("ovr_valid", {31'd0, rx_valid}, 32'h1);
    rx_ready = 1'b1;
    wait_clks(1);
    check("ovr_valid_cleared", {31'd0, rx_valid}, 32'h0);
    check("ovr_queue",         exp_q.size(), 32'd0);

    // Reset in the middle of a frame.
    a0 = acc_cnt;
    fork
      send_byte(8'hFF, 1'b1, BIT_NS);
      begin
        wait_clks(40);
        check("mid_busy", {31'd0, busy}, 32'h1);
        rst = 1'b1;
        wait_clks(1);
        check("mid_rst_valid", {31'd0, rx_valid}, 32'h0);
        check("mid_rst_busy",  {31'd0, busy}, 32'h0);
        check("mid_rst_data",  {24'd0, rx_data}, 32'h0);
        rst = 1'b0;
      end
    join
    wait_clks(10);
    check("mid_no_byte", acc_cnt, a0);
    exp_q.push_back(8'h5A);
    send_byte(8'h5A, 1'b1, BIT_NS);
    wait_clks(20);
    check("post_rst_accepts", acc_cnt, a0 + 1);
    check("post_rst_queue",   exp_q.size(), 32'd0);

    // Baud skew of roughly +/-3 percent.
    a0 = acc_cnt; f0 = ferr_cyc;
    exp_q.push_back(8'h00); send_byte(8'h00, 1'b1, 103);
    exp_q.push_back(8'hFF); send_byte(8'hFF, 1'b1, 97);
    exp_q.push_back(8'h00); send_byte(8'h00, 1'b1, 97);
    exp_q.push_back(8'hFF); send_byte(8'hFF, 1'b1, 103);
    wait_clks(20);
    check("skew_accepts", acc_cnt, a0 + 4);
    check("skew_ferr",    ferr_cyc, f0);
    check("skew_queue",   exp_q.size(), 32'd0);
    check("total_ovr",    ovr_cnt, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
